// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead add/sub with saturation, NZVC flags and
// valid/ready back-pressure. The carry chain is cut between the two halves.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);
    localparam int H  = WIDTH / 2;
    localparam int NG = H / GROUP;

    // Group generate/propagate for the block-level carry chain: {G, P}
    function automatic logic [1:0] grp_gp(input logic [3:0] g, input logic [3:0] p);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
    endfunction

    function automatic logic [3:0] grp_sum(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return p ^ c;
    endfunction

    // One half of the datapath: {carry_out, sum}
    function automatic logic [H:0] half_add(input logic [H-1:0] x, input logic [H-1:0] y, input logic ci);
        logic [H-1:0] g, p, s;
        logic [NG:0]  cg;
        logic [1:0]   gp;
        g     = x & y;
        p     = x ^ y;
        s     = '0;
        cg    = '0;
        cg[0] = ci;
        for (int k = 0; k < NG; k++) begin
            gp        = grp_gp(g[GROUP*k +: 4], p[GROUP*k +: 4]);
            cg[k+1]   = gp[1] | (gp[0] & cg[k]);
            s[GROUP*k +: 4] = grp_sum(g[GROUP*k +: 4], p[GROUP*k +: 4], cg[k]);
        end
        return {cg[NG], s};
    endfunction

    logic             s1_valid_q, s2_valid_q;
    logic [H-1:0]     lo_sum_q, a_hi_q, b_hi_q;
    logic             c_mid_q, sat_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, z_q, v_q, c_q, v_d, c_d;
    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] beff, raw;
    logic [H:0]       lo, hi;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign beff = mode[0] ? ~b : b;
    assign lo   = half_add(a[H-1:0], beff[H-1:0], mode[0]);

    always_comb begin
        hi       = half_add(a_hi_q, b_hi_q, c_mid_q);
        raw      = {hi[H-1:0], lo_sum_q};
        c_d      = hi[H];
        v_d      = (a_hi_q[H-1] == b_hi_q[H-1]) && (raw[WIDTH-1] != a_hi_q[H-1]);
        result_d = raw;
        if (sat_q && v_d)
            result_d = a_hi_q[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            c_mid_q    <= 1'b0;
            sat_q      <= 1'b0;
            result_q   <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            c_q        <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    lo_sum_q <= lo[H-1:0];
                    c_mid_q  <= lo[H];
                    a_hi_q   <= a[WIDTH-1:H];
                    b_hi_q   <= beff[WIDTH-1:H];
                    sat_q    <= mode[1];
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    n_q      <= result_d[WIDTH-1];
                    z_q      <= (result_d == '0);
                    v_q      <= v_d;
                    c_q      <= c_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_v    = v_q;
    assign flag_c    = c_q;
endmodule
